// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the single-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic {ARB, LOCKED} state_t;

    localparam int MAX_BUS = 512;
    localparam int MAX_W   = 64;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Extract field idx of width w from a packed bus (bus zero-extended to MAX_BUS).
    function automatic logic [MAX_W-1:0] slice_get(input logic [MAX_BUS-1:0] bus, input int idx, input int w);
        return MAX_W'(bus >> (idx * w)) & ((MAX_W'(1) << w) - MAX_W'(1));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [NUM_REQ-1:0] rot;
    logic [IW-1:0]      off;

    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        off = '0;
        any = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) off = IW'(i);
        idx   = IW'((int'(ptr) + int'(off)) % NUM_REQ);
        grant = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port Mem among NUM_REQ requesters,
// with locked read-modify-write sequences and a pipelined response path matching Mem read latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             lock_err,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wr_data,
    output logic                             mem_wr_en,
    input  logic [DATA_WIDTH-1:0]            mem_rd_data
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    state_t             state, state_nxt;
    logic [IW-1:0]      ptr, owner, g;
    logic [CW-1:0]      cnt;
    logic [NUM_REQ-1:0] elig, grant;
    logic               any, acc_we, acc_lock, idle_hit;

    // While locked only the owner is eligible; reset masks every grant.
    always_comb begin
        elig = rst ? '0 : (state == LOCKED ? req_valid & (NUM_REQ'(1) << owner) : req_valid);
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (elig),
        .ptr   (ptr),
        .grant (grant),
        .idx   (g),
        .any   (any)
    );

    always_comb begin
        req_ready   = grant;
        acc_we      = any & req_we[g];
        acc_lock    = any & req_lock[g];
        mem_wr_en   = acc_we;
        mem_addr    = any ? ADDR_WIDTH'(slice_get(MAX_BUS'(req_addr), int'(g), ADDR_WIDTH)) : '0;
        mem_wr_data = any ? DATA_WIDTH'(slice_get(MAX_BUS'(req_wdata), int'(g), DATA_WIDTH)) : '0;
        idle_hit    = (state == LOCKED) && !any && (cnt == CW'(LOCK_TIMEOUT - 1));
        state_nxt   = any ? (acc_lock ? LOCKED : ARB) : (idle_hit ? ARB : state);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            ptr      <= '0;
            owner    <= '0;
            cnt      <= '0;
            lock_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_err <= idle_hit;
            cnt      <= (state == LOCKED && !any) ? cnt + 1'b1 : '0;
            if (any) begin
                ptr   <= (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
                owner <= g;
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb
            always_comb begin
                rsp_valid = grant;
                rsp_rdata = (any && !acc_we) ? mem_rd_data : '0;
            end
        end else begin : g_pipe
            logic [NUM_REQ-1:0] v_q  [READ_LATENCY];
            logic               rd_q [READ_LATENCY];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < READ_LATENCY; i++) begin
                        v_q[i]  <= '0;
                        rd_q[i] <= 1'b0;
                    end
                end else begin
                    v_q[0]  <= grant;
                    rd_q[0] <= any & ~acc_we;
                    for (int i = 1; i < READ_LATENCY; i++) begin
                        v_q[i]  <= v_q[i-1];
                        rd_q[i] <= rd_q[i-1];
                    end
                end
            end
            always_comb begin
                rsp_valid = v_q[READ_LATENCY-1];
                rsp_rdata = rd_q[READ_LATENCY-1] ? mem_rd_data : '0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives READ_LATENCY=1 and READ_LATENCY=0 instances with shared stimulus
// and compares both against a transaction-level reference of grants, locks and memory contents.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_we, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;

    logic [N-1:0]  r1_ready, r1_rv, r0_ready, r0_rv;
    logic [DW-1:0] r1_rd, r0_rd, m1_wdata, m0_wdata, m0_rdd;
    logic [DW-1:0] m1_rdd = '0;
    logic [AW-1:0] m1_addr, m0_addr;
    logic          r1_lerr, r0_lerr, m1_we, m0_we;

    logic [DW-1:0] mem1 [256] = '{default: '0};
    logic [DW-1:0] mem0 [256] = '{default: '0};

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .LOCK_TIMEOUT(TO)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r1_ready), .req_we(req_we),
        .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(r1_rv),
        .rsp_rdata(r1_rd), .lock_err(r1_lerr), .mem_addr(m1_addr), .mem_wr_data(m1_wdata),
        .mem_wr_en(m1_we), .mem_rd_data(m1_rdd));

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(0), .LOCK_TIMEOUT(TO)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r0_ready), .req_we(req_we),
        .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(r0_rv),
        .rsp_rdata(r0_rd), .lock_err(r0_lerr), .mem_addr(m0_addr), .mem_wr_data(m0_wdata),
        .mem_wr_en(m0_we), .mem_rd_data(m0_rdd));

    // Mem models: registered write-first read for mode 1, combinational read for mode 0.
    always @(posedge clk) begin
        if (m1_we) mem1[m1_addr[7:0]] <= m1_wdata;
        m1_rdd <= m1_we ? m1_wdata : mem1[m1_addr[7:0]];
    end
    always @(posedge clk) if (m0_we) mem0[m0_addr[7:0]] <= m0_wdata;
    assign m0_rdd = mem0[m0_addr[7:0]];

    int checks = 0;
    int passed = 0;

    int            m_ptr, m_owner, m_idle, p_idx;
    bit            m_locked, m_lerr, p_valid, p_rd;
    logic [DW-1:0] p_data;
    logic [DW-1:0] model_mem [256] = '{default: '0};

    logic [N-1:0]  obs_ready, obs_rv1, obs_rv0;
    logic [DW-1:0] obs_rd1, obs_rd0;
    logic          obs_lerr;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [N-1:0] oh(input int g);
        return (g < 0) ? '0 : N'(1 << g);
    endfunction

    function automatic int model_grant();
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_idle = 0; m_locked = 0; m_lerr = 0; p_valid = 0; p_rd = 0; p_idx = 0; p_data = '0;
    endtask

    // One clock: sample and check just after the falling edge, then advance the reference at the rising edge.
    task automatic cycle();
        int g;
        logic [DW-1:0] rd;
        logic [7:0] a;
        #1;
        g = model_grant();
        a = (g >= 0) ? req_addr[g*AW +: 8] : 8'd0;
        rd = (g >= 0 && !req_we[g]) ? model_mem[a] : '0;
        obs_ready = r1_ready; obs_rv1 = r1_rv; obs_rd1 = r1_rd; obs_rv0 = r0_rv; obs_rd0 = r0_rd; obs_lerr = r1_lerr;
        chk("ready_l1", r1_ready, oh(g));
        chk("ready_l0", r0_ready, oh(g));
        chk("mem_wr_en", m1_we, (g >= 0) && req_we[g]);
        if (g >= 0) begin
            chk("mem_addr", m1_addr, req_addr[g*AW +: AW]);
            if (req_we[g]) chk("mem_wr_data", m1_wdata, req_wdata[g*DW +: DW]);
        end
        chk("rsp_valid_l0", r0_rv, oh(g));
        chk("rsp_rdata_l0", r0_rd, rd);
        chk("rsp_valid_l1", r1_rv, p_valid ? oh(p_idx) : '0);
        chk("rsp_rdata_l1", r1_rd, p_rd ? p_data : '0);
        chk("lock_err_l1", r1_lerr, m_lerr);
        chk("lock_err_l0", r0_lerr, m_lerr);
        m_lerr = 0;
        p_valid = (g >= 0); p_idx = g; p_rd = (g >= 0) && !req_we[g]; p_data = rd;
        if (g >= 0) begin
            if (req_we[g]) model_mem[a] = req_wdata[g*DW +: DW];
            m_ptr = (g + 1) % N;
            m_locked = req_lock[g];
            m_owner = g;
            m_idle = 0;
        end else if (m_locked) begin
            m_idle++;
            if (m_idle == TO) begin
                m_locked = 0; m_lerr = 1; m_ptr = (m_owner + 1) % N;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic new_req(input int i);
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_we[i]    = $urandom_range(0, 1) == 1;
        req_lock[i]  = ($urandom_range(0, 7) == 0);
        req_addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
        req_wdata[i*DW +: DW] = $urandom;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Random traffic, then an asynchronous reset in the middle of a busy cycle.
        for (int i = 0; i < N; i++) new_req(i);
        req_lock = '0;
        repeat (6) cycle();
        req_valid = '1; req_we = '0; req_lock = '0;
        cycle();
        #3 rst = 1'b1;
        #1;
        chk("rst_ready_l1", r1_ready, 0);   chk("rst_ready_l0", r0_ready, 0);
        chk("rst_rsp_l1", r1_rv, 0);        chk("rst_rsp_l0", r0_rv, 0);
        chk("rst_rdata_l1", r1_rd, 0);      chk("rst_rdata_l0", r0_rd, 0);
        chk("rst_lerr", {r1_lerr, r0_lerr}, 0);
        chk("rst_mem_we", {m1_we, m0_we}, 0);
        chk("rst_mem_addr", {m1_addr, m0_addr}, 0);
        chk("rst_mem_wdata", {m1_wdata, m0_wdata}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Grant order after reset, then alternating fairness with a wrapping pointer.
        tbl[0] = '{4'b1111, 4'b0001}; tbl[1] = '{4'b1111, 4'b0010}; tbl[2] = '{4'b1111, 4'b0100};
        tbl[3] = '{4'b1111, 4'b1000}; tbl[4] = '{4'b1111, 4'b0001}; tbl[5] = '{4'b1010, 4'b0010};
        tbl[6] = '{4'b1010, 4'b1000}; tbl[7] = '{4'b1010, 4'b0010}; tbl[8] = '{4'b1010, 4'b1000};
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i);
        for (int i = 0; i < 9; i++) begin
            req_valid = tbl[i].valid;
            cycle();
            chk("tbl_grant", obs_ready, tbl[i].exp);
        end

        // Write then read the same address.
        req_valid = 4'b0001; req_we = 4'b0001;
        req_addr[0 +: AW] = 16'h0010; req_wdata[0 +: DW] = 32'hDEADBEEF;
        cycle();
        req_we = '0;
        cycle();
        chk("wr_rd_l0_valid", obs_rv0, 4'b0001);
        chk("wr_rd_l0_data", obs_rd0, 32'hDEADBEEF);
        req_valid = '0;
        cycle();
        chk("wr_rd_l1_valid", obs_rv1, 4'b0001);
        chk("wr_rd_l1_data", obs_rd1, 32'hDEADBEEF);

        // Locked sequence owned by requester 2.
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(16'h20 + i);
        req_valid = 4'b0100; req_lock = 4'b0100;
        cycle(); chk("lock_take", obs_ready, 4'b0100);
        req_valid = 4'b1111;
        cycle(); chk("lock_hold", obs_ready, 4'b0100);
        req_valid = 4'b1011;
        cycle(); chk("lock_block", obs_ready, 4'b0000);
        req_valid = 4'b1111; req_we = 4'b0100; req_lock = '0;
        cycle(); chk("lock_release", obs_ready, 4'b0100);
        req_valid = 4'b1011; req_we = '0;
        cycle(); chk("lock_after", obs_ready, 4'b1000);

        // Lock timeout: requester 1 locks then goes idle.
        req_valid = 4'b0010; req_lock = 4'b0010;
        cycle(); chk("to_take", obs_ready, 4'b0010);
        req_valid = 4'b1001; req_lock = '0;
        for (int i = 0; i < TO; i++) begin
            cycle();
            chk("to_idle", {obs_ready, obs_lerr}, 0);
        end
        cycle();
        chk("to_lerr", obs_lerr, 1'b1);
        chk("to_grant3", obs_ready, 4'b1000);
        cycle();
        chk("to_lerr_clear", obs_lerr, 1'b0);
        chk("to_grant0", obs_ready, 4'b0001);

        // Back-to-back reads from all requesters: one response per cycle in issue order.
        req_valid = 4'b1111; req_we = '0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("b2b_rsp_l0", obs_rv0, oh((1 + k) % N));
            if (k > 0) chk("b2b_rsp_l1", obs_rv1, oh(k % N));
        end

        // Randomized traffic; requesters hold their request until it is accepted.
        for (int i = 0; i < N; i++) new_req(i);
        for (int c = 0; c < 400; c++) begin
            cycle();
            for (int i = 0; i < N; i++)
                if (obs_ready[i] || !req_valid[i]) new_req(i);
        end

        req_valid = '0;
        repeat (2) cycle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
